// File: rtl/sensor_if_pkg.sv
`default_nettype none
// ============================================================================
// sensor_if_pkg : FSM states, pattern codes and counter widths shared by the
//                 sensor stream generator.   Revision: 1.0
// ============================================================================
package sensor_if_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  localparam logic [1:0] PAT_XRAMP = 2'd0;
  localparam logic [1:0] PAT_YRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FCNT  = 2'd3;

  localparam int HCNT_W = 12;
  localparam int VCNT_W = 11;

endpackage
`default_nettype wire

// File: rtl/sensor_pattern_src.sv
`default_nettype none
// ============================================================================
// sensor_pattern_src : combinational test-pattern pixel generator; the parent
//                      registers the result.   Revision: 1.0
// ============================================================================
module sensor_pattern_src
  import sensor_if_pkg::*;
(
  input  logic [1:0] pattern,
  input  logic [7:0] h_cnt,
  input  logic [7:0] y_cnt,
  input  logic [7:0] frame_cnt,
  output logic [7:0] pixel
);

  always_comb begin
    pixel = 8'h00;
    case (pattern)
      PAT_XRAMP: pixel = h_cnt;
      PAT_YRAMP: pixel = y_cnt;
      PAT_CHECK: pixel = (h_cnt[3] ^ y_cnt[3]) ? 8'hFF : 8'h00;
      PAT_FCNT:  pixel = frame_cnt;
      default:   pixel = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sensor_stream_gen.sv
`default_nettype none
// ============================================================================
// sensor_stream_gen : CMOS-sensor style vsync/href/data transmitter with frame
//                     timing and synthetic test patterns.   Revision: 1.0
// ============================================================================
module sensor_stream_gen
  import sensor_if_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       image_out_vsync,
  output logic       image_out_href,
  output logic [7:0] image_out_data,
  output logic       frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;

  localparam logic [HCNT_W-1:0] c_h_last  = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] c_h_act   = HCNT_W'(H_ACTIVE);
  localparam logic [VCNT_W-1:0] c_vs_last = VCNT_W'(V_SYNC - 1);
  localparam logic [VCNT_W-1:0] c_vb_last = VCNT_W'(V_BACK - 1);
  localparam logic [VCNT_W-1:0] c_va_last = VCNT_W'(V_ACTIVE - 1);
  localparam logic [VCNT_W-1:0] c_vf_last = VCNT_W'(V_FRONT - 1);

  // Zero-length back/front porches are bypassed rather than given a state.
  localparam state_t c_after_vsync = (V_BACK == 0) ? ACTIVE : VBACK;
  localparam logic   c_skip_front  = (V_FRONT == 0);

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_wrap_state;
  logic [HCNT_W-1:0]   r_h_cnt;
  logic [HCNT_W-1:0]   w_h_nxt;
  logic [VCNT_W-1:0]   r_v_cnt;
  logic [VCNT_W-1:0]   w_v_nxt;
  logic [VCNT_W-1:0]   r_y_cnt;
  logic [VCNT_W-1:0]   w_y_nxt;
  logic [1:0]          r_pat;
  logic [1:0]          w_pat_nxt;
  logic [7:0]          r_frame_cnt;
  logic [7:0]          w_pixel;
  logic                w_line_end;
  logic                w_href;
  logic                w_frame_end;

  assign w_line_end   = (r_h_cnt == c_h_last);
  assign w_wrap_state = enable ? VSYNC : IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_y_cnt <= '0;
      r_pat   <= PAT_XRAMP;
    end else begin
      r_state <= w_state_nxt;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_y_cnt <= w_y_nxt;
      r_pat   <= w_pat_nxt;
    end
  end

  // enable is only consulted in IDLE and at the last line of a frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = VSYNC;
      end
      VSYNC: begin
        if (w_line_end && (r_v_cnt == c_vs_last)) w_state_nxt = c_after_vsync;
      end
      VBACK: begin
        if (w_line_end && (r_v_cnt == c_vb_last)) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (w_line_end && (r_v_cnt == c_va_last))
          w_state_nxt = c_skip_front ? w_wrap_state : VFRONT;
      end
      VFRONT: begin
        if (w_line_end && (r_v_cnt == c_vf_last)) w_state_nxt = w_wrap_state;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_h_nxt   = '0;
    w_v_nxt   = r_v_cnt;
    w_y_nxt   = r_y_cnt;
    w_pat_nxt = r_pat;

    if (r_state != IDLE)
      w_h_nxt = w_line_end ? '0 : r_h_cnt + 1'b1;

    if (w_state_nxt != r_state)
      w_v_nxt = '0;
    else if (w_line_end && (r_state != IDLE))
      w_v_nxt = r_v_cnt + 1'b1;

    if (w_state_nxt != ACTIVE)
      w_y_nxt = '0;
    else if ((r_state == ACTIVE) && w_line_end)
      w_y_nxt = r_y_cnt + 1'b1;

    // The pattern is frozen for the whole frame from VSYNC entry on.
    if ((w_state_nxt == VSYNC) && (r_state != VSYNC))
      w_pat_nxt = pattern_sel;
  end

  assign w_href      = (r_state == ACTIVE) && (r_h_cnt < c_h_act);
  // h_cnt == H_ACTIVE on the last line is the cycle right after the last pixel.
  assign w_frame_end = (r_state == ACTIVE) && (r_y_cnt == c_va_last) &&
                       (r_h_cnt == c_h_act);

  sensor_pattern_src u_pattern (
    .pattern   (r_pat),
    .h_cnt     (r_h_cnt[7:0]),
    .y_cnt     (r_y_cnt[7:0]),
    .frame_cnt (r_frame_cnt),
    .pixel     (w_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image_out_vsync <= 1'b1;
      image_out_href  <= 1'b0;
      image_out_data  <= 8'h00;
      frame_done      <= 1'b0;
      r_frame_cnt     <= 8'h00;
    end else begin
      image_out_vsync <= (r_state != VSYNC);
      image_out_href  <= w_href;
      image_out_data  <= w_href ? w_pixel : 8'h00;
      frame_done      <= w_frame_end;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sensor_stream_gen.sv
`default_nettype none
// ============================================================================
// tb_sensor_stream_gen : self-checking bench for sensor_stream_gen using a
//                        frame vector table and a pixel scoreboard.  Rev: 1.0
// ============================================================================
module tb_sensor_stream_gen;

  localparam int c_h_act   = 8;
  localparam int c_h_blank = 4;
  localparam int c_frame   = 84;

  typedef struct {
    logic [1:0] pat;
    int         mid_act;   // 0 none, 1 change pattern_sel, 2 drop enable
    logic [1:0] mid_pat;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       vsync, href, done;
  logic [7:0] data;
  logic       en16;
  logic [1:0] pat16;
  logic       vs16, href16, done16;
  logic [7:0] data16;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] q[$];
  logic [7:0] q16[$];
  int exp_fidx = 0;
  int n16 = 0;

  int f_vs_low = 0, f_href = 0, f_bursts = 0, f_done = 0;
  logic [7:0] f_first = 8'h00, f_last = 8'h00;
  int g_vs_low = 0, g_href = 0, g_done = 0;
  int burst = 0, gap = 0, idle_viol = 0;
  int last_fall = 0, prev_fall = 0;
  logic prev_vs = 1'b1, prev_href = 1'b0;
  int c_set = 0;

  vec_t tbl[7];

  sensor_stream_gen #(
    .H_ACTIVE(8), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .image_out_vsync(vsync), .image_out_href(href), .image_out_data(data),
    .frame_done(done)
  );

  sensor_stream_gen #(
    .H_ACTIVE(16), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .enable(en16), .pattern_sel(pat16),
    .image_out_vsync(vs16), .image_out_href(href16), .image_out_data(data16),
    .frame_done(done16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] exp_pix(input logic [1:0] p, input int x,
                                         input int y, input int f);
    case (p)
      2'd0:    return 8'(x);
      2'd1:    return 8'(y);
      2'd2:    return ((((x / 8) + (y / 8)) % 2) == 1) ? 8'hFF : 8'h00;
      default: return 8'(f % 256);
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] p);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < c_h_act; x++)
        q.push_back(exp_pix(p, x, y, exp_fidx));
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return !vsync;
      1:       return done;
      2:       return href;
      3:       return !vs16;
      default: return done16;
    endcase
  endfunction

  task automatic wait_for(input int s, input int budget, input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sig(s) !== 1'b1 && k < budget);
    check(nm, sig(s), 1);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 8-pixel instance: frame statistics and scoreboard pops.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vs   = 1'b1;
      prev_href = 1'b0;
    end else begin
      if (prev_vs && !vsync) begin
        prev_fall = last_fall;
        last_fall = cyc;
        f_vs_low = 0; f_href = 0; f_bursts = 0; f_done = 0;
      end
      if (!vsync) begin
        f_vs_low++;
        g_vs_low++;
      end
      if (href) begin
        if (!prev_href) begin
          if (f_bursts > 0) check("href_gap", gap, c_h_blank);
          burst = 0;
          gap   = 0;
          f_bursts++;
        end
        burst++;
        if (q.size() == 0) check("sb_underflow", 1, 0);
        else check("pixel", data, q.pop_front());
        if (f_href == 0) f_first = data;
        f_last = data;
        f_href++;
        g_href++;
      end else begin
        if (prev_href) check("href_burst_len", burst, c_h_act);
        gap++;
        if (data != 8'h00) idle_viol++;
      end
      if (done) begin
        f_done++;
        g_done++;
        check("done_timing", {prev_href, href}, 2'b10);
      end
      prev_vs   = vsync;
      prev_href = href;
    end
  end

  always @(negedge clk) begin
    if (rst_n && href16) begin
      if (q16.size() == 0) check("sb16_underflow", 1, 0);
      else check("pixel16", data16, q16.pop_front());
      n16++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd3, 0, 2'd0, 8'd0, 8'd0};
    tbl[1] = '{2'd3, 0, 2'd0, 8'd1, 8'd1};
    tbl[2] = '{2'd3, 0, 2'd0, 8'd2, 8'd2};
    tbl[3] = '{2'd0, 0, 2'd0, 8'd0, 8'd7};
    tbl[4] = '{2'd1, 0, 2'd0, 8'd0, 8'd3};
    tbl[5] = '{2'd3, 1, 2'd0, 8'd5, 8'd5};
    tbl[6] = '{2'd0, 2, 2'd0, 8'd0, 8'd7};

    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; en16 = 1'b0; pat16 = 2'd0;
    repeat (3) step();
    check("rst_vsync", vsync, 1);
    check("rst_href", href, 0);
    check("rst_data", data, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    g_vs_low = 0; g_href = 0; g_done = 0;
    repeat (50) step();
    check("idle_vsync_low", g_vs_low, 0);
    check("idle_href", g_href, 0);
    check("idle_done", g_done, 0);

    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        pattern_sel = tbl[0].pat;
        enable = 1'b1;
        push_frame(tbl[0].pat);
        c_set = cyc;
      end
      wait_for(0, 60, "vsync_fall_wait");
      step();
      if (i == 0) check("vsync_latency", last_fall - c_set, 2);
      else check("frame_period", last_fall - prev_fall, c_frame);
      if (tbl[i].mid_act != 0) begin
        repeat (30) step();
        if (tbl[i].mid_act == 1) pattern_sel = tbl[i].mid_pat;
        else enable = 1'b0;
      end
      wait_for(1, 200, "frame_done_wait");
      step();
      check("done_one_cycle", done, 0);
      exp_fidx++;
      if (i + 1 < 7) begin
        pattern_sel = tbl[i+1].pat;
        push_frame(tbl[i+1].pat);
      end
      check("vsync_low_len", f_vs_low, 12);
      check("href_cycles", f_href, 32);
      check("href_lines", f_bursts, 4);
      check("done_pulses", f_done, 1);
      check("first_pix", f_first, tbl[i].exp_first);
      check("last_pix", f_last, tbl[i].exp_last);
    end

    g_vs_low = 0; g_href = 0;
    repeat (100) step();
    check("stopped_vsync_low", g_vs_low, 0);
    check("stopped_href", g_href, 0);
    check("sb_empty_after_stop", q.size(), 0);

    // Asynchronous reset in the middle of an active line.
    pattern_sel = 2'd0;
    enable = 1'b1;
    push_frame(2'd0);
    wait_for(2, 120, "href_wait");
    step();
    check("pre_reset_href", href, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_href", href, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_vsync", vsync, 1);
    check("mid_rst_done", done, 0);
    enable = 1'b0;
    repeat (5) step();
    q.delete();
    rst_n = 1'b1;
    exp_fidx = 0;
    g_vs_low = 0;
    repeat (30) step();
    check("post_rst_idle", g_vs_low, 0);

    pattern_sel = 2'd3;
    enable = 1'b1;
    push_frame(2'd3);
    c_set = cyc;
    wait_for(0, 60, "vsync_fall_wait2");
    step();
    check("vsync_latency2", last_fall - c_set, 2);
    enable = 1'b0;
    wait_for(1, 200, "frame_done_wait2");
    step();
    check("post_rst_href_cycles", f_href, 32);
    check("post_rst_fcnt", f_first, 0);

    // Checkerboard on the 16-pixel instance.
    pat16 = 2'd2;
    en16 = 1'b1;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 16; x++)
        q16.push_back(exp_pix(2'd2, x, y, 0));
    wait_for(3, 60, "vsync16_fall_wait");
    step();
    en16 = 1'b0;
    wait_for(4, 400, "frame_done16_wait");
    step();
    check("pixel16_count", n16, 64);
    check("sb16_empty", q16.size(), 0);

    repeat (20) step();
    check("idle_data_zero", idle_viol, 0);
    check("sb_empty_end", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
